// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path:
// frame FSM states, frame bit levels and payload width.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic PS2_START     = 1'b0;
    localparam logic PS2_STOP      = 1'b1;
    localparam int   PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO for received scancodes.
// Ports: clk/rst, push+din, pop, dout (0 when empty), full, empty, count.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // A push into a full FIFO is still accepted when a pop frees a slot
    // in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, scancode FIFO.
// Ports: CLK, reset, keyboard_clock/data (raw pins), rd_en/rd_data/rd_valid/
// fifo_count (CPU pop side), frame_err pulse, overflow (sticky), clr_status.
module ps2_keyboard_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 32000
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          keyboard_clock,
    input  logic                          keyboard_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_status
);

    import ps2_pkg::*;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] flt_cnt;
    logic          fall_stb;

    ps2_state_t    state;
    logic [BW-1:0] bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] to_cnt;

    logic          ok_par;
    logic          stop_ok;
    logic          push;
    logic          timeout_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_set;

    // Sync and filter state idle high so reset never looks like an edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_clk <= 1'b1;
            flt_cnt  <= '0;
            fall_stb <= 1'b0;
        end else begin
            clk_s1   <= keyboard_clock;
            clk_s2   <= clk_s1;
            dat_s1   <= keyboard_data;
            dat_s2   <= dat_s1;
            fall_stb <= 1'b0;
            if (clk_s2 == filt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                // FILTER_LEN-th consecutive differing sample: accept it.
                filt_clk <= clk_s2;
                flt_cnt  <= '0;
                fall_stb <= ~clk_s2;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign ok_par  = ^{shift, par_bit};
    assign stop_ok = (dat_s2 == PS2_STOP);
    assign push    = fall_stb && (state == ST_STOP) && ok_par && stop_ok;

    // A falling edge on the same cycle as expiry keeps the frame alive.
    assign timeout_hit = (state != ST_IDLE) && !fall_stb &&
                         (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (timeout_hit) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                shift     <= '0;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else if (fall_stb) begin
                to_cnt <= '0;
                unique case (state)
                    ST_IDLE: begin
                        if (dat_s2 == PS2_START) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!(ok_par && stop_ok)) frame_err <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (shift),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd_valid = ~fifo_empty;
    assign ovf_set  = push && fifo_full && !(rd_en && !fifo_empty);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_status) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/ps2_keyboard_ctrl.md
Name: ps2_keyboard_ctrl

Overview:
Receive-side controller for the PS/2 keyboard pins (keyboard_clock, keyboard_data) on the TinyFPGA BX design. Synchronizes and de-glitches the device-driven clock, then sequences the 11-bit PS/2 frame. It checks parity and stop bit, and buffers good scancodes in a FIFO. The CPU pops bytes through a simple read handshake. Runs in the 16 MHz CPU clock domain.

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries; power of 2, minimum 2
FILTER_LEN, 4, consecutive equal synchronized samples required before the filtered PS/2 clock changes
TIMEOUT_CYCLES, 32000, CLK cycles without a falling edge mid-frame before the frame is aborted (2 ms at 16 MHz)

Ports:
CLK  in  1  system clock, 16 MHz
reset  in  1  asynchronous, active-high reset
keyboard_clock  in  1  raw PS/2 clock from pin, asynchronous
keyboard_data  in  1  raw PS/2 data from pin, asynchronous
rd_en  in  1  CPU pop request; honoured only when rd_valid=1
rd_data  out  8  FIFO head, first-word-fall-through; 8'h00 when empty
rd_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored bytes
frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error
overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full
clr_status  in  1  clears overflow

Behaviour:
- Reset (async assert, sync deassert internally not required): FSM=IDLE, bit counter=0, shift reg=0, timeout counter=0, FIFO empty. Synchronizer and filter state preset to 1 (idle bus high), so reset never creates a spurious edge. Outputs: rd_data=0, rd_valid=0, fifo_count=0, frame_err=0, overflow=0.
- Input path: 2-flop synchronizer on both inputs. Filtered clock takes a new value only after FILTER_LEN consecutive identical synchronized samples. fall_stb = filtered clock 1->0, single-cycle strobe. Data is sampled from synchronized data on the fall_stb cycle.
- FSM, advancing only on fall_stb except for timeout:
  - IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift right, MSB in (LSB-first on wire). After the 8th bit go to PARITY.
  - PARITY: capture p. ok_par = XOR(byte, p)==1 (odd parity). Go to STOP.
  - STOP: stop ok = data==1. If ok_par and stop ok, push byte; otherwise pulse frame_err. Return to IDLE.
- Timeout: the counter runs when the FSM is not in IDLE and clears on every fall_stb. Reaching TIMEOUT_CYCLES-1 forces IDLE, discards the partial byte and pulses frame_err. The counter is idle (0) in IDLE.
- Latency: the push occurs on the STOP fall_stb cycle N. rd_valid and fifo_count update at N+1. From the physical falling edge to fall_stb is 2+FILTER_LEN cycles.
- FIFO:
  - Push when full and no pop: byte dropped, overflow<=1, count stays at FIFO_DEPTH.
  - Push and pop in the same cycle when full: both are performed, no overflow, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_status and an overflow set in the same cycle: set wins.
- frame_err and a push never coincide (mutually exclusive by construction).

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - PS2_START=1'b0, PS2_STOP=1'b1
  - PS2_DATA_BITS=8
- Sub-module ps2_fifo: synchronous FWFT FIFO with push, pop, full, empty and count. Parameterized by depth and width (8).
- Sync/filter logic stays inline.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz PS/2 clock -> rd_valid=1, rd_data=8'h1C, fifo_count=1, frame_err never high. Then rd_en one cycle -> rd_valid=0, rd_data=8'h00.
- Frame 0x1C with parity=1 -> single frame_err pulse, fifo_count=0. Frame 0x1C with stop=0 -> frame_err pulse, fifo_count=0.
- 9 good frames 0x01..0x09 with no reads (FIFO_DEPTH=8) -> fifo_count=8, overflow=1. Pops return 0x01..0x08 in order. clr_status -> overflow=0.
- Idle bus, 2-cycle low glitch on keyboard_clock with data=0 (FILTER_LEN=4) -> FSM remains IDLE. A following frame 0xF0 is received correctly.
- Start bit plus 3 data bits, then the clock held high -> frame_err pulse exactly TIMEOUT_CYCLES after the last edge. A following frame 0xE0 is received correctly.
- reset asserted after 5 data bits of 0x5A, released, then a full frame 0x5A -> no push from the aborted frame, fifo_count=1, rd_data=8'h5A.
